uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmitter (tx_start/tx_data/tx_busy interface) between NUM_REQ byte
//   requesters. Arbitration is round-robin, with optional packet lock: a requester keeps the
//   grant until it sends a byte with req_last=1. Sits between client logic and the UART TX core.
// PARAMETERS
//   NUM_REQ       4      number of requesters (>=2); IDW = max(1,$clog2(NUM_REQ))
//   BUSY_TIMEOUT  16     cycles to wait for tx_busy to rise after tx_start before flagging error
//   LOCK_TIMEOUT  1024   idle cycles a locked requester may stall before its lock is dropped
// PORTS
//   clk          in   1          system clock, all logic on rising edge
//   rst          in   1          asynchronous, active-high reset
//   req_valid    in   NUM_REQ    per-requester byte available
//   req_data     in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//   req_last     in   NUM_REQ    byte ends packet (releases lock)
//   req_ready    out  NUM_REQ    one-cycle pulse: byte of requester i accepted
//   tx_start     out  1          one-cycle start pulse to UART TX
//   tx_data      out  8          byte to UART TX, stable from tx_start until tx_busy falls
//   tx_busy      in   1          UART TX busy flag
//   grant_valid  out  1          a requester holds the grant (byte in flight or lock held)
//   grant_id     out  IDW        index of current/last granted requester
//   err_timeout  out  1          sticky: tx_busy failed to rise within BUSY_TIMEOUT
// BEHAVIOUR
//   - Reset: state IDLE, all outputs 0, rr pointer so requester 0 has top priority, lock clear,
//     counters 0. Reset mid-transfer abandons the byte; no further tx_start until new request.
//   - All outputs registered. FSM: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//   - IDLE: arbitrate only when tx_busy=0. If lock held, only the locked requester is eligible;
//     else winner = first valid index searching from (last grant+1) mod NUM_REQ upward, wrapping.
//     On winner w: next edge sets req_ready[w]=1, tx_start=1, tx_data=req_data[w], grant_id=w,
//     grant_valid=1, lock=~req_last[w]; state LAUNCH. Latency valid->ready/start: 1 cycle.
//   - LAUNCH (1 cycle): req_ready, tx_start return to 0 at next edge; state WAIT_BUSY.
//     Requesters hold valid/data stable until they see req_ready; valid ignored outside IDLE.
//   - WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Counter counts cycles here; reaching BUSY_TIMEOUT
//     -> err_timeout=1 (sticky until rst), lock cleared, grant_valid=0, state IDLE.
//   - WAIT_DONE: tx_busy=0 -> IDLE; if lock clear, grant_valid=0 and rr pointer advances past
//     grant_id; if lock held, grant_valid stays 1.
//   - Lock stall: in IDLE with lock held and locked req_valid=0, idle counter increments; at
//     LOCK_TIMEOUT lock clears, grant_valid=0, pointer advances; counter resets on any grant.
//   - Simultaneous requests: exactly one req_ready bit per grant; never two tx_start pulses
//     without an intervening tx_busy high->low (or timeout).
//   - tx_busy high in IDLE (foreign/late busy): no grant until it falls.
// TESTING
//   1. req_valid=0001, data0=A5, last0=1 -> cycle 1: req_ready=0001, tx_start=1, tx_data=A5,
//      grant_id=0; after tx_busy 1->0: grant_valid=0, state IDLE.
//   2. After reset, req_valid=1111 held, all last=1, bytes 10/11/12/13 -> tx_data sequence
//      10,11,12,13,10 with grant_id 0,1,2,3,0; one req_ready bit per grant.
//   3. Req1 sends 3 bytes (last only on 3rd), req2 valid throughout -> grants 1,1,1 then 2;
//      grant_valid stays 1 between req1 bytes.
//   4. Tie tx_busy=0 after tx_start -> err_timeout=1 exactly BUSY_TIMEOUT cycles into
//      WAIT_BUSY; next request still granted and err_timeout stays 1.
//   5. Assert rst during WAIT_DONE -> all outputs 0 immediately; after release with
//      req_valid=1010, requester 1 granted first.
//   6. Req1 sends byte last=0 then drops valid; req3 valid -> req3 granted only after
//      LOCK_TIMEOUT idle cycles; grant_valid=0 for one cycle before the req3 grant.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Lets NUM_REQ byte requesters share a single UART transmitter. Requesters are
// served round-robin. A requester that sends a byte with req_last=0 locks the
// grant, so its next byte follows without interleaving. A locked requester
// that stalls in IDLE for LOCK_TIMEOUT cycles loses the lock. If the UART never
// raises tx_busy after a start pulse, the arbiter gives up after BUSY_TIMEOUT
// cycles and sets a sticky error flag.
//
// Ports
//   clk          in   1            system clock, rising edge
//   rst          in   1            asynchronous, active-high reset
//   req_valid    in   NUM_REQ      requester i has a byte available
//   req_data     in   8*NUM_REQ    byte of requester i at [8*i+7:8*i]
//   req_last     in   NUM_REQ      byte ends the requester's packet
//   req_ready    out  NUM_REQ      one-cycle pulse: byte of requester i taken
//   tx_start     out  1            one-cycle start pulse to the UART TX core
//   tx_data      out  8            byte to the UART, held until the next grant
//   tx_busy      in   1            UART TX busy flag
//   grant_valid  out  1            a requester holds the grant
//   grant_id     out  IDW          index of the current / last granted requester
//   err_timeout  out  1            sticky: tx_busy never rose after tx_start
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int BUSY_TIMEOUT = 16,
    parameter  int LOCK_TIMEOUT = 1024,
    localparam int IDW          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [IDW-1:0]       grant_id,
    output logic                 err_timeout
);

    localparam int BCW = $clog2(BUSY_TIMEOUT + 1);
    localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [BCW-1:0] BUSY_LAST = BCW'(BUSY_TIMEOUT - 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t               state_q,       state_d;
    logic [IDW-1:0]       rr_ptr_q,      rr_ptr_d;      // highest-priority index
    logic                 lock_q,        lock_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [IDW-1:0]       grant_id_q,    grant_id_d;
    logic [NUM_REQ-1:0]   req_ready_q,   req_ready_d;
    logic                 tx_start_q,    tx_start_d;
    logic [7:0]           tx_data_q,     tx_data_d;
    logic                 err_q,         err_d;
    logic [BCW-1:0]       busy_cnt_q,    busy_cnt_d;
    logic [LCW-1:0]       idle_cnt_q,    idle_cnt_d;

    logic                 win_found;
    logic [IDW-1:0]       win_id;

    // Index following id, wrapping at NUM_REQ (which need not be a power of 2).
    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + IDW'(1);
    endfunction

    // Arbitration: a held lock restricts eligibility to the locked requester;
    // otherwise pick the first valid requester at or after the rr pointer.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        if (lock_q) begin
            win_found = req_valid[grant_id_q];
            win_id    = grant_id_q;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                    win_found = 1'b1;
                    win_id    = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
                end
            end
        end
    end

    // Next-state and output logic.
    // NOTE: every _d is given its hold value before the case statement, so no
    // path through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_d        = lock_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        err_d         = err_q;
        busy_cnt_d    = busy_cnt_q;
        idle_cnt_d    = idle_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!tx_busy && win_found) begin
                    req_ready_d[win_id] = 1'b1;
                    tx_start_d          = 1'b1;
                    tx_data_d           = req_data[8*int'(win_id) +: 8];
                    grant_id_d          = win_id;
                    grant_valid_d       = 1'b1;
                    lock_d              = ~req_last[win_id];
                    idle_cnt_d          = '0;
                    state_d             = S_LAUNCH;
                end else if (lock_q && !req_valid[grant_id_q]) begin
                    // Locked requester has gone quiet: drop the lock after
                    // LOCK_TIMEOUT stalled cycles so others are not starved.
                    if (idle_cnt_q == LOCK_LAST) begin
                        lock_d        = 1'b0;
                        grant_valid_d = 1'b0;
                        rr_ptr_d      = next_id(grant_id_q);
                        idle_cnt_d    = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + LCW'(1);
                    end
                end
            end

            S_LAUNCH: begin
                busy_cnt_d = '0;
                state_d    = S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (busy_cnt_q == BUSY_LAST) begin
                    // UART never acknowledged; abandon the byte and the packet.
                    err_d         = 1'b1;
                    lock_d        = 1'b0;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = next_id(grant_id_q);
                    state_d       = S_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + BCW'(1);
                end
            end

            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                    if (!lock_q) begin
                        grant_valid_d = 1'b0;
                        rr_ptr_d      = next_id(grant_id_q);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this clock edge, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            lock_q        <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            err_q         <= 1'b0;
            busy_cnt_q    <= '0;
            idle_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_q        <= lock_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            err_q         <= err_d;
            busy_cnt_q    <= busy_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, BUSY_TIMEOUT=16,
// LOCK_TIMEOUT=1024). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so each tick() shows the result of
// exactly one clock edge. The UART is played by hand through tx_busy.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        err_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .BUSY_TIMEOUT (16),
        .LOCK_TIMEOUT (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, req_ready,   0);
        check({tag, "_start"}, tx_start,    0);
        check({tag, "_data"},  tx_data,     0);
        check({tag, "_gv"},    grant_valid, 0);
        check({tag, "_id"},    grant_id,    0);
        check({tag, "_err"},   err_timeout, 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Grant is expected exactly one edge after the current input setup.
    task automatic expect_grant(input string tag, input int exp_id, input logic [7:0] exp_data);
        tick();
        check({tag, "_start"}, tx_start,    1);
        check({tag, "_id"},    grant_id,    exp_id);
        check({tag, "_data"},  tx_data,     exp_data);
        check({tag, "_ready"}, req_ready,   32'(1) << exp_id);
        check({tag, "_gv"},    grant_valid, 1);
    endtask

    // UART side of one byte: busy rises after the start pulse, then falls.
    task automatic finish_byte(input string tag, input logic [7:0] exp_data, input bit exp_gv);
        tick();
        check({tag, "_start_pulse"}, tx_start,  0);
        check({tag, "_ready_pulse"}, req_ready, 0);
        tx_busy = 1'b1;
        tick();
        tick();
        check({tag, "_data_hold"}, tx_data, exp_data);
        tx_busy = 1'b0;
        tick();
        check({tag, "_gv_after"}, grant_valid, exp_gv);
    endtask

    initial begin
        int bad;

        // Reset state
        do_reset();
        check_all_zero("reset");

        // 1: single requester, one-cycle latency, grant released afterwards
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        req_last  = 4'b0001;
        expect_grant("t1", 0, 8'hA5);
        req_valid = 4'b0000;
        finish_byte("t1", 8'hA5, 1'b0);

        // 2: all four requesting, round-robin 0,1,2,3,0
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        req_last  = 4'b1111;
        expect_grant("t2_g0", 0, 8'h10); finish_byte("t2_g0", 8'h10, 1'b0);
        expect_grant("t2_g1", 1, 8'h11); finish_byte("t2_g1", 8'h11, 1'b0);
        expect_grant("t2_g2", 2, 8'h12); finish_byte("t2_g2", 8'h12, 1'b0);
        expect_grant("t2_g3", 3, 8'h13); finish_byte("t2_g3", 8'h13, 1'b0);
        expect_grant("t2_g4", 0, 8'h10); finish_byte("t2_g4", 8'h10, 1'b0);

        // 3: packet lock on req1 (3 bytes) holds off req2
        do_reset();
        req_valid = 4'b0110;
        req_data  = 32'h0022_3100;
        req_last  = 4'b0100;
        expect_grant("t3_b1", 1, 8'h31); finish_byte("t3_b1", 8'h31, 1'b1);
        req_data  = 32'h0022_3200;
        expect_grant("t3_b2", 1, 8'h32); finish_byte("t3_b2", 8'h32, 1'b1);
        req_data  = 32'h0022_3300;
        req_last  = 4'b0110;
        expect_grant("t3_b3", 1, 8'h33);
        req_valid = 4'b0100;
        finish_byte("t3_b3", 8'h33, 1'b0);
        expect_grant("t3_r2", 2, 8'h22);
        req_valid = 4'b0000;
        finish_byte("t3_r2", 8'h22, 1'b0);

        // 4: tx_busy never rises -> error exactly 16 cycles into WAIT_BUSY
        do_reset();
        req_valid = 4'b0100;
        req_data  = 32'h0044_0000;
        req_last  = 4'b0100;
        expect_grant("t4", 2, 8'h44);
        req_valid = 4'b0000;
        bad = 0;
        repeat (16) begin
            tick();
            if (err_timeout !== 1'b0 || tx_start !== 1'b0) bad++;
        end
        check("t4_no_early_err", bad, 0);
        check("t4_gv_before", grant_valid, 1);
        tick();
        check("t4_err_set", err_timeout, 1);
        check("t4_gv_drop", grant_valid, 0);
        req_valid = 4'b0010;
        req_data  = 32'h0000_5500;
        req_last  = 4'b0010;
        expect_grant("t4_next", 1, 8'h55);
        req_valid = 4'b0000;
        finish_byte("t4_next", 8'h55, 1'b0);
        check("t4_err_sticky", err_timeout, 1);

        // 5: asynchronous reset during WAIT_DONE
        req_valid = 4'b0001;
        req_data  = 32'h0000_0077;
        req_last  = 4'b0001;
        expect_grant("t5_pre", 0, 8'h77);
        req_valid = 4'b0000;
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        tx_busy = 1'b0;
        tick();
        tick();
        rst       = 1'b0;
        req_valid = 4'b1010;
        req_data  = 32'h6300_6100;
        req_last  = 4'b1010;
        expect_grant("t5_first", 1, 8'h61);
        req_valid = 4'b1000;
        finish_byte("t5_first", 8'h61, 1'b0);
        req_valid = 4'b0000;

        // 6: locked requester stalls; lock dropped after LOCK_TIMEOUT cycles
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_7100;
        req_last  = 4'b0000;
        expect_grant("t6_lock", 1, 8'h71);
        finish_byte("t6_lock", 8'h71, 1'b1);
        req_valid = 4'b1000;
        req_data  = 32'h7300_0000;
        req_last  = 4'b1000;
        bad = 0;
        repeat (1023) begin
            tick();
            if (tx_start !== 1'b0 || grant_valid !== 1'b1) bad++;
        end
        check("t6_no_early_grant", bad, 0);
        tick();
        check("t6_gv_gap", grant_valid, 0);
        check("t6_gap_start", tx_start, 0);
        expect_grant("t6_r3", 3, 8'h73);
        req_valid = 4'b0000;
        finish_byte("t6_r3", 8'h73, 1'b0);

        // Foreign busy in IDLE blocks arbitration until it falls
        req_valid = 4'b0001;
        req_data  = 32'h0000_00AB;
        req_last  = 4'b0001;
        tx_busy   = 1'b1;
        bad = 0;
        repeat (3) begin
            tick();
            if (tx_start !== 1'b0 || grant_valid !== 1'b0) bad++;
        end
        check("busy_idle_block", bad, 0);
        tx_busy = 1'b0;
        expect_grant("busy_idle_grant", 0, 8'hAB);
        req_valid = 4'b0000;
        finish_byte("busy_idle", 8'hAB, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
